// File: rtl/mem_stream_reader.sv
// Sequential word read-back engine: issues credit-limited memory reads from a base address
// and streams the returned words out of a small FIFO over a valid/ready interface.
module mem_stream_reader #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_STEP  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [31:0] word_count,
    output logic [31:0] mem_addr,
    output logic        mem_rw,
    output logic        mem_en,
    input  logic [31:0] mem_data,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW:0] DepthLimit = (CntW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [31:0]     ptr_q, ptr_d;
    logic [31:0]     remaining_q, remaining_d;
    logic            inflight_q;
    logic [31:0]     fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic [CntW:0]   credit_used;
    logic            push, pop;

    // A read in flight already owns a FIFO slot, so it counts against the credit.
    assign credit_used = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
    assign mem_en      = (state_q == StRun) && (credit_used < DepthLimit);
    assign mem_addr    = ptr_q;
    assign mem_rw      = 1'b1;

    assign push      = inflight_q;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign count_d   = count_q + CntW'(push) - CntW'(pop);
    assign out_data  = out_valid ? fifo_mem[rd_ptr_q] : 32'h0;

    assign busy = (state_q == StRun) || (state_q == StDrain);
    assign done = (state_q == StDone);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    ptr_d       = base_addr;
                    remaining_d = word_count;
                    state_d     = (word_count != 32'd0) ? StRun : StDone;
                end
            end
            StRun: begin
                if (mem_en) begin
                    ptr_d       = ptr_q + ADDR_STEP;
                    remaining_d = remaining_q - 32'd1;
                    if (remaining_q == 32'd1) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Finish on the edge that pops the final word.
                if (!inflight_q && (count_d == '0)) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            ptr_q       <= 32'h0;
            remaining_q <= 32'h0;
            inflight_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            inflight_q  <= mem_en;
            count_q     <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= mem_data;
        end
    end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Bench for mem_stream_reader: memory model, queue-based reference model checked every
// negedge, plus directed scenarios with literal expectations.
module tb_mem_stream_reader;

    localparam int unsigned Depth = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start;
    logic [31:0] base_addr;
    logic [31:0] word_count;
    logic [31:0] mem_addr;
    logic        mem_rw;
    logic        mem_en;
    logic [31:0] mem_data;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    mem_stream_reader #(.FIFO_DEPTH(Depth), .ADDR_STEP(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .mem_addr   (mem_addr),
        .mem_rw     (mem_rw),
        .mem_en     (mem_en),
        .mem_data   (mem_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    // Memory: explicit preload where given, otherwise an address hash.
    logic [31:0] preload [logic [31:0]];

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (preload.exists(a)) return preload[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    // Synchronous read; data is garbage except the cycle after an issue.
    always @(posedge clock) mem_data <= mem_en ? mem_val(mem_addr) : $urandom();

    // Reference model state
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] addr_log[$];
    logic [31:0] data_log[$];
    int phase = 0;                  // 0 idle, 1 transferring, 2 done
    int iss_total = 0, iss_lag = 0, pops = 0, landed = 0, cyc = 0;
    int start_cyc = 0, first_valid_cyc = -1, pop_first_cyc = -1, pop_last_cyc = -1;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = 32'h0;
    logic        exp_en, exp_valid;

    initial forever begin
        @(negedge clock);
        cyc++;
        if (reset) begin
            check("rst_mem_en", mem_en, 1'b0);
            check("rst_out_valid", out_valid, 1'b0);
            check("rst_out_data", out_data, 32'h0);
            check("rst_busy", busy, 1'b0);
            check("rst_done", done, 1'b0);
            check("rst_mem_addr", mem_addr, 32'h0);
            exp_addr.delete();
            exp_data.delete();
            phase = 0; iss_total = 0; iss_lag = 0; pops = 0; prev_stall = 1'b0;
        end else begin
            // A word issued two negedges ago is visible in the FIFO now.
            landed  = iss_lag;
            iss_lag = iss_total;
            exp_valid = (landed > pops);
            check("out_valid", out_valid, exp_valid);
            if (out_valid && exp_data.size() > 0) check("out_data", out_data, exp_data[0]);
            check("mem_rw", mem_rw, 1'b1);
            exp_en = (exp_addr.size() > 0) && ((iss_total - pops) < int'(Depth));
            check("mem_en", mem_en, exp_en);
            if (mem_en) begin
                if (exp_addr.size() > 0) begin
                    check("mem_addr", mem_addr, exp_addr[0]);
                    void'(exp_addr.pop_front());
                end
                addr_log.push_back(mem_addr);
                iss_total++;
            end
            check("busy", busy, phase == 1);
            check("done", done, phase == 2);
            if (prev_stall) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_data", out_data, prev_data);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid && out_ready) begin
                data_log.push_back(out_data);
                if (exp_data.size() > 0) void'(exp_data.pop_front());
                pops++;
                if (pop_first_cyc < 0) pop_first_cyc = cyc;
                pop_last_cyc = cyc;
            end
            if (phase == 1 && exp_addr.size() == 0 && exp_data.size() == 0) phase = 2;
            if (start && phase != 1) begin
                addr_log.delete();
                data_log.delete();
                start_cyc = cyc;
                first_valid_cyc = -1; pop_first_cyc = -1; pop_last_cyc = -1;
                for (int n = 0; n < int'(word_count); n++) begin
                    exp_addr.push_back(base_addr + 32'(n) * 32'd4);
                    exp_data.push_back(mem_val(base_addr + 32'(n) * 32'd4));
                end
                phase = (word_count != 32'd0) ? 1 : 2;
            end
        end
    end

    task automatic pulse_start(input logic [31:0] b, input logic [31:0] c);
        @(posedge clock); #1;
        base_addr = b; word_count = c; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        // Changing these mid-transfer must have no effect.
        base_addr = 32'hDEAD_BEEF; word_count = 32'd7;
    endtask

    task automatic wait_done(input string name, input int max);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clock); #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, seen, 1'b1);
    endtask

    function automatic logic [31:0] log_at(input int k, input logic is_addr);
        if (is_addr) return (addr_log.size() > k) ? addr_log[k] : 32'hxxxx_xxxx;
        return (data_log.size() > k) ? data_log[k] : 32'hxxxx_xxxx;
    endfunction

    initial begin
        logic [31:0] t1_words [4];
        logic [31:0] t5_addrs [4];
        t1_words = '{32'hABCD_ABCD, 32'hDEFA_DEFA, 32'h1234_1234, 32'h0BAD_F00D};
        t5_addrs = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        for (int k = 0; k < 4; k++) preload[32'(k * 4)] = t1_words[k];
        start = 1'b0; base_addr = 32'h0; word_count = 32'h0; out_ready = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("init_mem_en", mem_en, 1'b0);
        check("init_mem_addr", mem_addr, 32'h0);
        check("init_out_valid", out_valid, 1'b0);
        check("init_done", done, 1'b0);
        reset = 1'b0;

        // 1: four preloaded words, consumer always ready
        out_ready = 1'b1;
        pulse_start(32'h0, 32'd4);
        wait_done("t1_done", 20);
        // Start is seen on the negedge before its accepting edge, hence +3 negedges.
        check("t1_first_valid", 32'(first_valid_cyc - start_cyc), 32'd3);
        check("t1_back_to_back", 32'(pop_last_cyc - pop_first_cyc), 32'd3);
        check("t1_done_after_pop", 32'(cyc - pop_last_cyc), 32'd1);
        for (int k = 0; k < 4; k++) begin
            check("t1_word", log_at(k, 1'b0), t1_words[k]);
            check("t1_addr", log_at(k, 1'b1), 32'(k * 4));
        end

        // 2: back-pressure fills the FIFO, then drains
        out_ready = 1'b0;
        pulse_start(32'h0, 32'd10);
        repeat (10) @(negedge clock);
        #1;
        check("t2_issues_full", 32'(addr_log.size()), 32'd4);
        check("t2_stall_en", mem_en, 1'b0);
        check("t2_stall_addr", mem_addr, 32'h10);
        check("t2_full_valid", out_valid, 1'b1);
        @(posedge clock); #1;
        out_ready = 1'b1;
        wait_done("t2_done", 100);
        check("t2_words", 32'(data_log.size()), 32'd10);
        check("t2_last_word", log_at(9, 1'b0), mem_val(32'h24));

        // 3: random back-pressure over 100 words
        pulse_start(32'h200, 32'd100);
        for (int i = 0; i < 2000; i++) begin
            @(posedge clock); #1;
            out_ready = 1'($urandom_range(0, 1));
            if (done) break;
        end
        check("t3_done", done, 1'b1);
        out_ready = 1'b1;
        check("t3_words", 32'(data_log.size()), 32'd100);

        // 4: zero-length transfer
        pulse_start(32'h80, 32'd0);
        @(negedge clock); #1;
        check("t4_done", done, 1'b1);
        check("t4_out_valid", out_valid, 1'b0);
        repeat (3) @(negedge clock);
        #1;
        check("t4_no_issue", 32'(addr_log.size()), 32'd0);

        // 5: address wrap
        pulse_start(32'hFFFF_FFF8, 32'd4);
        wait_done("t5_done", 20);
        for (int k = 0; k < 4; k++) begin
            check("t5_addr", log_at(k, 1'b1), t5_addrs[k]);
            check("t5_word", log_at(k, 1'b0), mem_val(t5_addrs[k]));
        end

        // 6: reset with two words buffered and one read in flight
        out_ready = 1'b0;
        pulse_start(32'h300, 32'd3);
        repeat (3) @(posedge clock);
        #1;
        check("t6_pre_valid", out_valid, 1'b1);
        check("t6_pre_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check("t6_rst_valid", out_valid, 1'b0);
        check("t6_rst_en", mem_en, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        @(negedge clock);
        @(posedge clock); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        pulse_start(32'h40, 32'd2);
        wait_done("t6_done", 20);
        check("t6_words", 32'(data_log.size()), 32'd2);
        check("t6_word0", log_at(0, 1'b0), mem_val(32'h40));
        check("t6_word1", log_at(1, 1'b0), mem_val(32'h44));

        repeat (2) @(negedge clock);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mem_stream_reader.md
Name: mem_stream_reader

Overview:
Sequential read-back engine for the unified memory block. On start, it issues word reads (rw=1) from a base address, stepping by 4 bytes per word, for a programmed word count. Returned words are buffered in a small FIFO and streamed out over a valid/ready interface. It is the read-side counterpart to the program loader that writes word images into memory, and it serves as the fetch front end for instruction streaming and memory dump/compare benches.

Parameters:
FIFO_DEPTH, 4, output buffer entries; power of two, minimum 2.
ADDR_STEP, 4, byte increment between consecutive word reads.

Ports:
clock  in  1  system clock; all state updates on posedge.
reset  in  1  asynchronous, active-high reset.
start  in  1  one-cycle pulse; sampled only in IDLE or DONE.
base_addr  in  32  first byte address; captured on accepted start.
word_count  in  32  number of words to read; captured on accepted start.
mem_addr  out  32  address to memory.
mem_rw  out  1  1=read; this block never writes.
mem_en  out  1  memory enable; high only on cycles that issue a read.
mem_data  in  32  memory read data; valid exactly 1 cycle after an issuing cycle.
out_data  out  32  head-of-FIFO word.
out_valid  out  1  FIFO non-empty.
out_ready  in  1  consumer accepts out_data when out_valid & out_ready.
busy  out  1  high in RUN and DRAIN.
done  out  1  high in DONE.

Behaviour:
- Reset (async, any state including mid-transfer): state=IDLE; mem_addr=0; mem_rw=1; mem_en=0; FIFO emptied; out_valid=0; out_data=0; busy=0; done=0; in-flight read discarded.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE --start--> RUN if word_count!=0. Otherwise IDLE --start--> DONE in 1 cycle.
  - RUN: issues reads. Moves to DRAIN on the cycle the last read is issued.
  - DRAIN: waits for the last return, then for the FIFO to empty. Then moves to DONE.
  - DONE --start--> same as from IDLE. start is ignored in RUN and DRAIN.
- Issue rule: in RUN, mem_en=1 iff (fifo_count + inflight) < FIFO_DEPTH, where inflight is 0 or 1.
  - Each issue presents mem_addr = current pointer, then pointer += ADDR_STEP and remaining -= 1.
  - First issue occurs the cycle after start is accepted.
- Return capture: the cycle after an issue, mem_data is pushed into the FIFO. The credit rule guarantees no overflow and no dropped return.
- Address arithmetic: 32-bit, wraps modulo 2^32 (0xFFFFFFFC + 4 -> 0x00000000) with no error.
- Word order is preserved: the nth word output is the word at base_addr + n*ADDR_STEP.
- Output handshake:
  - out_data and out_valid are driven from FIFO state, not combinationally from mem_data.
  - A pop occurs on out_valid & out_ready.
  - A simultaneous push and pop in one cycle is legal and leaves the count unchanged.
  - out_data holds its value while out_valid & !out_ready.
- Throughput: with out_ready held high, one word per cycle sustained after a 2-cycle initial latency. The first out_valid appears 2 cycles after start is accepted.
- Full FIFO: issuing stalls with mem_en=0. mem_addr holds the next pointer. Issuing resumes the cycle after a pop frees credit.
- When not issuing, mem_en=0 and mem_addr holds its last value. mem_rw is constant 1.
- base_addr and word_count may change after start with no effect on the current transfer.

Test Plan:
1. Preload memory 0x00..0x0C with 0xABCDABCD, 0xDEFADEFA, 0x12341234, 0x0BADF00D; start with base=0, count=4, out_ready=1 -> 4 words output in order on consecutive cycles; first out_valid at start+2; done asserted after the 4th pop; mem_addr sequence is 0, 4, 8, C.
2. count=10, FIFO_DEPTH=4, out_ready=0 -> exactly 4 issues, then mem_en=0 with fifo full and mem_addr=0x10. Raise out_ready -> remaining 6 words issue; all 10 words are correct and none dropped or duplicated.
3. Random out_ready toggling over count=100 from base=0x200 -> output matches the memory model word-for-word; out_data is stable while stalled.
4. start with count=0 -> no mem_en pulse; done=1 one cycle later; out_valid stays 0.
5. base=0xFFFFFFF8, count=4 -> addresses FFFFFFF8, FFFFFFFC, 00000000, 00000004; data correct.
6. Assert reset mid-RUN with 2 words buffered and a read in flight -> same cycle: out_valid=0, mem_en=0, busy=0. After release, a new start of count=2 yields only the new 2 words.
